stream_pkt_arbiter: RTL and testbench

STREAM_PKT_ARBITER -- requirements
Module: stream_pkt_arbiter

---
 rtl/stream_pkt_arbiter.sv | 151 +++++++++++++++
 tb/tb_stream_pkt_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_pkt_arbiter.sv
// Packet-locked round-robin arbiter for NUM_REQUEST AXI-Stream sources into one registered
// output stream, with a sticky flag for packets longer than MAX_BEATS.
module stream_pkt_arbiter #(
  parameter int unsigned NUM_REQUEST = 2,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MAX_BEATS   = 8,
  localparam int unsigned WIDTH_ID   = $clog2(NUM_REQUEST)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQUEST-1:0]            s_tvalid_i,
  input  logic [NUM_REQUEST*DATA_WIDTH-1:0] s_tdata_i,
  input  logic [NUM_REQUEST-1:0]            s_tlast_i,
  output logic [NUM_REQUEST-1:0]            s_tready_o,
  output logic                              m_tvalid_o,
  output logic [DATA_WIDTH-1:0]             m_tdata_o,
  output logic                              m_tlast_o,
  output logic [WIDTH_ID-1:0]               m_tid_o,
  input  logic                              m_tready_i,
  output logic                              busy_o,
  output logic                              err_len_o
);

  localparam int unsigned CntW = $clog2(MAX_BEATS + 2);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                state_q, state_d;
  logic [WIDTH_ID-1:0]   prio_ptr_q, prio_ptr_d;
  logic [WIDTH_ID-1:0]   grant_q, grant_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                  m_tlast_q, m_tlast_d;
  logic [WIDTH_ID-1:0]   m_tid_q, m_tid_d;

  logic [DATA_WIDTH-1:0] s_data [NUM_REQUEST];

  for (genvar k = 0; k < NUM_REQUEST; k++) begin : g_split
    assign s_data[k] = s_tdata_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Circular first-set search starting at prio_ptr_q.
  logic                pick_valid;
  logic [WIDTH_ID-1:0] pick_id;
  int unsigned         idx;

  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int unsigned i = 0; i < NUM_REQUEST; i++) begin
      idx = 32'(prio_ptr_q) + i;
      if (idx >= NUM_REQUEST) idx = idx - NUM_REQUEST;
      if (!pick_valid && s_tvalid_i[idx[WIDTH_ID-1:0]]) begin
        pick_valid = 1'b1;
        pick_id    = idx[WIDTH_ID-1:0];
      end
    end
  end

  logic out_free;
  logic accept;
  logic acc_last;

  assign out_free = !m_tvalid_q || m_tready_i;
  assign accept   = (state_q == StLocked) && out_free && s_tvalid_i[grant_q];
  assign acc_last = s_tlast_i[grant_q];

  always_comb begin
    s_tready_o = '0;
    if (state_q == StLocked && out_free) s_tready_o[grant_q] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    prio_ptr_d = prio_ptr_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    m_tid_d    = m_tid_q;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick_id;
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (accept) begin
          if (acc_last) begin
            state_d    = StIdle;
            cnt_d      = '0;
            prio_ptr_d = (grant_q == WIDTH_ID'(NUM_REQUEST - 1)) ? '0 : grant_q + 1'b1;
          end else begin
            // A non-last beat at position MAX_BEATS means the packet is oversize.
            if (cnt_q == CntW'(MAX_BEATS - 1)) err_d = 1'b1;
            if (cnt_q != CntW'(MAX_BEATS + 1)) cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = s_data[grant_q];
      m_tlast_d  = acc_last;
      m_tid_d    = grant_q;
    end else if (m_tready_i) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      prio_ptr_q <= '0;
      grant_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tid_q    <= '0;
    end else begin
      state_q    <= state_d;
      prio_ptr_q <= prio_ptr_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tlast_q  <= m_tlast_d;
      m_tid_q    <= m_tid_d;
    end
  end

  assign m_tvalid_o = m_tvalid_q;
  assign m_tdata_o  = m_tdata_q;
  assign m_tlast_o  = m_tlast_q;
  assign m_tid_o    = m_tid_q;
  assign busy_o     = (state_q == StLocked);
  assign err_len_o  = err_q;

endmodule

// File: tb/tb_stream_pkt_arbiter.sv
// Randomized bench for stream_pkt_arbiter: cycle-level reference model of the arbitration rules
// plus an in-order beat scoreboard between accepted source beats and delivered output beats.
module tb_stream_pkt_arbiter;

  localparam int N   = 3;
  localparam int DW  = 16;
  localparam int MAX = 8;
  localparam int IW  = $clog2(N);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    s_tvalid;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]    s_tlast;
  logic [N-1:0]    s_tready;
  logic            m_tvalid;
  logic [DW-1:0]   m_tdata;
  logic            m_tlast;
  logic [IW-1:0]   m_tid;
  logic            m_tready;
  logic            busy;
  logic            err_len;

  stream_pkt_arbiter #(
    .NUM_REQUEST(N),
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_tvalid_i(s_tvalid),
    .s_tdata_i (s_tdata),
    .s_tlast_i (s_tlast),
    .s_tready_o(s_tready),
    .m_tvalid_o(m_tvalid),
    .m_tdata_o (m_tdata),
    .m_tlast_o (m_tlast),
    .m_tid_o   (m_tid),
    .m_tready_i(m_tready),
    .busy_o    (busy),
    .err_len_o (err_len)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Source drivers
  bit vld [N];
  bit in_pkt [N];
  bit acc [N];
  int idx [N];
  int len [N];
  int seq [N];
  int vpct = 70, rpct = 70, lmin = 1, lmax = 5;
  bit rst_req = 1'b0;
  bit rst_rand = 1'b0;

  function automatic logic [DW-1:0] data_of(input int s);
    logic [3:0] a;
    logic [5:0] b;
    logic [5:0] c;
    a = 4'(s);
    b = 6'(seq[s]);
    c = 6'(idx[s]);
    return {a, b, c};
  endfunction

  function automatic bit last_of(input int s);
    return idx[s] == len[s] - 1;
  endfunction

  // Reference model state
  bit md_lock, md_ov, md_ol, md_err;
  int md_gnt, md_ptr, md_cnt, md_od, md_ot;

  typedef struct {int data; bit last; int src;} beat_t;
  beat_t sb[$];

  bit   phase_a = 1'b0;
  int   tid_log[$];

  task automatic model_step();
    bit found;
    int k;
    if (!rst_n) begin
      md_lock = 0; md_ov = 0; md_ol = 0; md_err = 0;
      md_gnt = 0; md_ptr = 0; md_cnt = 0; md_od = 0; md_ot = 0;
    end else if (!md_lock) begin
      if (m_tready) md_ov = 0;
      found = 0;
      for (int j = 0; j < N; j++) begin
        k = (md_ptr + j) % N;
        if (!found && vld[k]) begin
          found = 1; md_gnt = k; md_lock = 1;
        end
      end
    end else if (vld[md_gnt] && (!md_ov || m_tready)) begin
      md_ov = 1; md_od = int'(data_of(md_gnt)); md_ol = last_of(md_gnt); md_ot = md_gnt;
      if (md_ol) begin
        md_lock = 0; md_cnt = 0; md_ptr = (md_gnt + 1) % N;
      end else begin
        if (md_cnt == MAX - 1) md_err = 1;
        if (md_cnt < MAX + 1) md_cnt++;
      end
    end else if (m_tready) begin
      md_ov = 0;
    end
  endtask

  task automatic sample();
    int exp_rdy;
    beat_t b;
    exp_rdy = (md_lock && (!md_ov || m_tready)) ? (1 << md_gnt) : 0;
    check_eq("s_tready", s_tready, exp_rdy);
    check_eq("m_tvalid", m_tvalid, md_ov);
    check_eq("m_tdata", m_tdata, md_od);
    check_eq("m_tlast", m_tlast, md_ol);
    check_eq("m_tid", m_tid, md_ot);
    check_eq("busy", busy, md_lock);
    check_eq("err_len", err_len, md_err);
    for (int s = 0; s < N; s++) acc[s] = 0;
    if (!rst_n) return;
    if (m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 0, 1);
      end else begin
        b = sb.pop_front();
        check_eq("sb_data", m_tdata, b.data);
        check_eq("sb_last", m_tlast, b.last);
        check_eq("sb_src", m_tid, b.src);
      end
      if (phase_a && tid_log.size() < 8) tid_log.push_back(int'(m_tid));
    end
    for (int s = 0; s < N; s++) begin
      acc[s] = vld[s] && s_tready[s];
      if (acc[s]) begin
        b.data = int'(data_of(s)); b.last = last_of(s); b.src = s;
        sb.push_back(b);
      end
    end
  endtask

  task automatic drive();
    bit do_rst;
    do_rst = rst_req || (rst_rand && ($urandom % 100 == 0));
    rst_n = !do_rst;
    for (int s = 0; s < N; s++) begin
      if (do_rst) begin
        vld[s] = 0; in_pkt[s] = 0;
      end else begin
        if (acc[s]) begin
          if (last_of(s)) in_pkt[s] = 0;
          else idx[s]++;
          vld[s] = 0;
        end
        if (!vld[s] && ($urandom % 100 < vpct)) begin
          if (!in_pkt[s]) begin
            in_pkt[s] = 1; idx[s] = 0; seq[s]++;
            len[s] = $urandom_range(lmax, lmin);
          end
          vld[s] = 1;
        end
      end
      s_tvalid[s] = vld[s];
      s_tlast[s]  = last_of(s);
      s_tdata[s*DW +: DW] = data_of(s);
    end
    if (do_rst) sb.delete();
    m_tready = ($urandom % 100 < rpct);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      sample();
      @(posedge clk);
      model_step();
      #1;
      drive();
    end
  endtask

  initial begin
    int exp_tid [8] = '{0, 0, 1, 1, 2, 2, 0, 0};
    bit seen;
    rst_n = 0; s_tvalid = '0; s_tdata = '0; s_tlast = '0; m_tready = 0;
    for (int s = 0; s < N; s++) begin
      vld[s] = 0; in_pkt[s] = 0; acc[s] = 0; idx[s] = 0; len[s] = 1; seq[s] = 0;
    end
    @(posedge clk);
    model_step();
    #1;
    rst_req = 1;
    drive();
    vpct = 100; rpct = 100; lmin = 2; lmax = 2;
    run(2);

    // All sources busy, 2-beat packets, downstream always ready.
    rst_req = 0;
    phase_a = 1;
    run(30);
    phase_a = 0;
    check_eq("tid_log_len", tid_log.size(), 8);
    for (int i = 0; i < 8 && i < tid_log.size(); i++) check_eq("tid_seq", tid_log[i], exp_tid[i]);

    vpct = 70; rpct = 70; lmin = 1; lmax = 5;
    run(3000);
    check_eq("err_not_set", err_len, 0);

    // Oversize packets: 9 beats against MAX_BEATS=8.
    vpct = 90; rpct = 90; lmin = 9; lmax = 9;
    run(200);
    check_eq("err_sticky", err_len, 1);

    // Reset while locked with a beat held in the output register.
    vpct = 80; rpct = 30; lmin = 2; lmax = 6;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      run(1);
      if (md_lock && md_ov) seen = 1;
    end
    check_eq("rst_mid_seen", seen, 1);
    rst_req = 1;
    run(1);
    rst_req = 0;
    run(1);
    check_eq("rst_mid_tvalid", m_tvalid, 0);
    check_eq("rst_mid_err", err_len, 0);

    vpct = 60; rpct = 60; lmin = 1; lmax = 10; rst_rand = 1;
    run(3000);
    rst_rand = 0;
    run(50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
